// File: rtl/mem_stage_lsu_if.sv
// Execute/writeback handshake plus D-cache core bus bundle for mem_stage_lsu.
// master = the memory stage, slave = the surrounding pipeline and cache.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
);
  logic                in_valid, in_ready, in_is_load, in_is_store, in_sign;
  logic [ADDR_W-1:0]   in_addr;
  logic [63:0]         in_store_data;
  logic [1:0]          in_size;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid, out_ready, out_fault, stall_out;
  logic [63:0]         out_load_data;
  logic                req_cyc, req_we, req_ack;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_data;
  logic [DATA_W/8-1:0] req_be;
  logic [TAG_W-1:0]    req_tag;
  logic                resp_cyc, resp_ack;
  logic [DATA_W-1:0]   resp_data;

  modport master (
    input  in_valid, in_is_load, in_is_store, in_addr, in_store_data, in_size, in_sign, in_tag,
           out_ready, req_ack, resp_cyc, resp_data,
    output in_ready, out_valid, out_load_data, out_fault, stall_out,
           req_cyc, req_we, req_addr, req_data, req_be, req_tag, resp_ack
  );
  modport slave (
    output in_valid, in_is_load, in_is_store, in_addr, in_store_data, in_size, in_sign, in_tag,
           out_ready, req_ack, resp_cyc, resp_data,
    input  in_ready, out_valid, out_load_data, out_fault, stall_out,
           req_cyc, req_we, req_addr, req_data, req_be, req_tag, resp_ack
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Load/store memory stage: sub-word loads/stores, misalignment faults, writeback back-pressure.
// Optional bus watchdog enabled by defining MEM_STAGE_TIMEOUT_EN.
module mem_stage_lsu #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TAG_W          = 13,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic            clk,
  input  logic            reset,
  mem_stage_lsu_if.master bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, HOLD = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              req_we_q, req_we_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [BE_W-1:0]   req_be_q, req_be_d;
  logic [TAG_W-1:0]  req_tag_q, req_tag_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d, is_load_q, is_load_d;
  logic [63:0]       load_data_q, load_data_d;
  logic              fault_q, fault_d, resp_ack_q, resp_ack_d;
  logic [7:0]        lane_mask;
  logic [2:0]        sz_mask;
  logic              misal, tmo_hit;

  function automatic logic [63:0] extract(input logic [DATA_W-1:0] d, input logic [OFF_W-1:0] off,
                                          input logic [1:0] sz, input logic sgn);
    logic [DATA_W-1:0] sh;
    sh = d >> {off, 3'b000};
    case (sz)
      2'd0:    return {{56{sgn & sh[7]}},  sh[7:0]};
      2'd1:    return {{48{sgn & sh[15]}}, sh[15:0]};
      2'd2:    return {{32{sgn & sh[31]}}, sh[31:0]};
      default: return sh[63:0];
    endcase
  endfunction

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic             busy;

  // Counter sits at zero outside REQ/RESP, so entering REQ always starts from zero.
  always_comb begin
    busy    = (state_q == REQ) || (state_q == RESP);
    tmo_d   = busy ? tmo_q + 1'b1 : '0;
    tmo_hit = busy && (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    case (bus.in_size)
      2'd0:    begin lane_mask = 8'h01; sz_mask = 3'd0; end
      2'd1:    begin lane_mask = 8'h03; sz_mask = 3'd1; end
      2'd2:    begin lane_mask = 8'h0F; sz_mask = 3'd3; end
      default: begin lane_mask = 8'hFF; sz_mask = 3'd7; end
    endcase
    misal = |(bus.in_addr[2:0] & sz_mask);
  end

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_be_d    = req_be_q;
    req_tag_d   = req_tag_q;
    off_d       = off_q;
    size_d      = size_q;
    sign_d      = sign_q;
    is_load_d   = is_load_q;
    load_data_d = load_data_q;
    fault_d     = fault_q;
    resp_ack_d  = 1'b0;
    case (state_q)
      IDLE: begin
        resp_ack_d = bus.resp_cyc;  // stray response: ack and drop
        if (bus.in_valid) begin
          // load+store together is illegal; the load wins
          is_load_d   = bus.in_is_load;
          req_we_d    = bus.in_is_store & ~bus.in_is_load;
          off_d       = bus.in_addr[OFF_W-1:0];
          size_d      = bus.in_size;
          sign_d      = bus.in_sign;
          req_tag_d   = bus.in_tag;
          req_addr_d  = bus.in_addr & ~ADDR_W'(BE_W - 1);
          req_data_d  = DATA_W'(bus.in_store_data) << {bus.in_addr[OFF_W-1:0], 3'b000};
          req_be_d    = BE_W'(lane_mask) << bus.in_addr[OFF_W-1:0];
          load_data_d = '0;
          fault_d     = 1'b0;
          if (!(bus.in_is_load || bus.in_is_store)) state_d = HOLD;
          else if (misal) begin fault_d = 1'b1; state_d = HOLD; end
          else state_d = REQ;
        end
      end
      REQ: begin
        if (bus.req_ack) begin
          if (bus.resp_cyc) begin
            load_data_d = is_load_q ? extract(bus.resp_data, off_q, size_q, sign_q) : '0;
            resp_ack_d  = 1'b1;
            state_d     = HOLD;
          end else state_d = RESP;
        end else if (tmo_hit) begin
          fault_d = 1'b1; load_data_d = '0; state_d = HOLD;
        end
      end
      RESP: begin
        if (bus.resp_cyc) begin
          load_data_d = is_load_q ? extract(bus.resp_data, off_q, size_q, sign_q) : '0;
          resp_ack_d  = 1'b1;
          state_d     = HOLD;
        end else if (tmo_hit) begin
          fault_d = 1'b1; load_data_d = '0; state_d = HOLD;
        end
      end
      default: begin
        resp_ack_d = bus.resp_cyc;
        if (bus.out_ready) begin
          state_d = IDLE; load_data_d = '0; fault_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;  req_we_q <= 1'b0;  req_addr_q <= '0;  req_data_q <= '0;
      req_be_q <= '0;   req_tag_q <= '0;   off_q <= '0;       size_q <= '0;
      sign_q <= 1'b0;   is_load_q <= 1'b0; load_data_q <= '0; fault_q <= 1'b0;
      resp_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;  req_we_q <= req_we_d;   req_addr_q <= req_addr_d;   req_data_q <= req_data_d;
      req_be_q <= req_be_d; req_tag_q <= req_tag_d; off_q <= off_d;             size_q <= size_d;
      sign_q <= sign_d;    is_load_q <= is_load_d; load_data_q <= load_data_d; fault_q <= fault_d;
      resp_ack_q <= resp_ack_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.stall_out     = bus.in_valid & (state_q != IDLE);
  assign bus.out_valid     = (state_q == HOLD);
  assign bus.out_load_data = load_data_q;
  assign bus.out_fault     = fault_q;
  assign bus.req_cyc       = (state_q == REQ);
  assign bus.req_we        = req_we_q;
  assign bus.req_addr      = req_addr_q;
  assign bus.req_data      = req_data_q;
  assign bus.req_be        = req_be_q;
  assign bus.req_tag       = req_tag_q;
  assign bus.resp_ack      = resp_ack_q;

  a_no_ld_st: assert property (@(posedge clk) disable iff (!reset)
    (bus.in_valid && bus.in_ready) |-> !(bus.in_is_load && bus.in_is_store));
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: expected results queued at issue, compared at writeback.
module tb_mem_stage_lsu;
  localparam int ADDR_W = 64, DATA_W = 64, TAG_W = 13, TMO = 10;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_stage_lsu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus();
  mem_stage_lsu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .TIMEOUT_CYCLES(TMO))
    dut (.clk(clk), .reset(rst_n), .bus(bus.master));

  int               n_chk = 0, n_err = 0;
  logic [64:0]      sb[$];
  logic [64:0]      sb_e;
  logic [TAG_W-1:0] tag_ctr = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] d, input int off, input int nb, input logic sg);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = d[8*(off+i) +: 8];
    if (sg && r[8*nb-1]) for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        sb_e = sb.pop_front();
        chk("wb_data", bus.out_load_data, sb_e[63:0]);
        chk("wb_fault", 64'(bus.out_fault), 64'(sb_e[64]));
      end
    end
  end

  // resp_dly < 0: cache never answers (only meaningful with the watchdog)
  task automatic run_op(input string nm, input logic ld, input logic st, input logic [63:0] addr,
                        input logic [63:0] sdata, input logic [1:0] sz, input logic sg, input logic exp_req,
                        input int ack_dly, input int resp_dly, input logic [63:0] rdata, input int hold_dly,
                        input logic [63:0] exp_data, input logic exp_fault);
    logic [7:0] be;
    int wt;
    be = '0;
    for (int i = 0; i < (1 << sz); i++) be[int'(addr[2:0]) + i] = 1'b1;
    tag_ctr++;
    bus.in_valid = 1'b1; bus.in_is_load = ld; bus.in_is_store = st; bus.in_addr = addr;
    bus.in_store_data = sdata; bus.in_size = sz; bus.in_sign = sg; bus.in_tag = tag_ctr;
    #1 chk({nm, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({nm, ".stall_idle"}, 64'(bus.stall_out), 64'd0);
    sb.push_back({exp_fault, exp_data});
    step();
    bus.in_valid = 1'b0;
    if (exp_req) begin
      chk({nm, ".req_cyc"}, 64'(bus.req_cyc), 64'd1);
      chk({nm, ".req_we"}, 64'(bus.req_we), 64'(st));
      chk({nm, ".req_addr"}, bus.req_addr, addr & ~64'h7);
      chk({nm, ".req_be"}, 64'(bus.req_be), 64'(be));
      chk({nm, ".req_data"}, bus.req_data, sdata << (8 * addr[2:0]));
      chk({nm, ".req_tag"}, 64'(bus.req_tag), 64'(tag_ctr));
      for (int c = 0; c < ack_dly; c++) begin
        bus.in_valid = 1'b1;
        #1 chk({nm, ".stall"}, 64'(bus.stall_out), 64'd1);
        bus.in_valid = 1'b0;
        step();
        chk({nm, ".req_cyc_hold"}, 64'(bus.req_cyc), 64'd1);
        chk({nm, ".req_addr_hold"}, bus.req_addr, addr & ~64'h7);
        chk({nm, ".req_data_hold"}, bus.req_data, sdata << (8 * addr[2:0]));
      end
      bus.req_ack = 1'b1;
      if (resp_dly == 0) begin bus.resp_cyc = 1'b1; bus.resp_data = rdata; end
      step();
      bus.req_ack = 1'b0; bus.resp_cyc = 1'b0;
      chk({nm, ".req_drop"}, 64'(bus.req_cyc), 64'd0);
      if (resp_dly > 0) begin
        repeat (resp_dly - 1) step();
        bus.resp_cyc = 1'b1; bus.resp_data = rdata;
        step();
        bus.resp_cyc = 1'b0;
      end
      if (resp_dly >= 0) chk({nm, ".resp_ack"}, 64'(bus.resp_ack), 64'd1);
    end else begin
      chk({nm, ".no_req"}, 64'(bus.req_cyc), 64'd0);
    end
    wt = 0;
    while (!bus.out_valid && wt < 40) begin step(); wt++; end
    chk({nm, ".out_valid"}, 64'(bus.out_valid), 64'd1);
    if (!exp_req) chk({nm, ".fast_hold"}, 64'(wt), 64'd0);
    if (exp_req && resp_dly < 0) chk({nm, ".tmo_cycles"}, 64'(wt), 64'(TMO - 1));
    for (int c = 0; c < hold_dly; c++) begin
      step();
      chk({nm, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
      chk({nm, ".ack_1cyc"}, 64'(bus.resp_ack), 64'd0);
      chk({nm, ".hold_data"}, bus.out_load_data, exp_data);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({nm, ".ready_back"}, 64'(bus.in_ready), 64'd1);
    chk({nm, ".valid_drop"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [63:0] rd;
    logic        sg;
    int          off;
    bus.in_valid = 0; bus.in_is_load = 0; bus.in_is_store = 0; bus.in_addr = '0;
    bus.in_store_data = '0; bus.in_size = '0; bus.in_sign = 0; bus.in_tag = '0;
    bus.out_ready = 0; bus.req_ack = 0; bus.resp_cyc = 0; bus.resp_data = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.req_cyc", 64'(bus.req_cyc), 64'd0);
    chk("rst.resp_ack", 64'(bus.resp_ack), 64'd0);
    chk("rst.stall", 64'(bus.stall_out), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    run_op("ld8",    1, 0, 64'h1000, 64'h0, 2'd3, 0, 1, 0, 2, 64'h1122334455667788, 3, 64'h1122334455667788, 0);
    run_op("ldb_s",  1, 0, 64'h1003, 64'h0, 2'd0, 1, 1, 1, 1, 64'h0000000080000000, 0, 64'hFFFFFFFFFFFFFF80, 0);
    run_op("ldb_u",  1, 0, 64'h1003, 64'h0, 2'd0, 0, 1, 0, 1, 64'h0000000080000000, 1, 64'h0000000000000080, 0);
    run_op("st2",    0, 1, 64'h2006, 64'hBEEF, 2'd1, 0, 1, 0, 1, 64'hDEADDEADDEADDEAD, 1, 64'h0, 0);
    run_op("misal",  1, 0, 64'h3002, 64'h0, 2'd2, 0, 0, 0, 0, 64'h0, 1, 64'h0, 1);
    run_op("mis_st", 0, 1, 64'h2004, 64'h55, 2'd3, 0, 0, 0, 0, 64'h0, 0, 64'h0, 1);
    run_op("nop",    0, 0, 64'h5555, 64'h0, 2'd3, 0, 0, 0, 0, 64'h0, 0, 64'h0, 0);
    run_op("ld_b2b", 1, 0, 64'h100C, 64'h0, 2'd2, 1, 1, 4, 0, 64'h89ABCDEF01234567, 0, 64'hFFFFFFFF89ABCDEF, 0);

    for (int k = 0; k < 6; k++) begin
      sz  = 2'($urandom_range(0, 3));
      off = int'($urandom_range(0, 7)) & ~((1 << sz) - 1);
      rd  = {$urandom, $urandom};
      sg  = 1'($urandom_range(0, 1));
      run_op("rnd_ld", 1, 0, 64'h8000 + 64'(off), 64'h0, sz, sg, 1, int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), rd, int'($urandom_range(0, 2)), model_load(rd, off, 1 << sz, sg), 0);
    end

    bus.resp_cyc = 1'b1; bus.resp_data = 64'hFFFF;
    step();
    bus.resp_cyc = 1'b0;
    chk("stray.ack", 64'(bus.resp_ack), 64'd1);
    chk("stray.idle", 64'(bus.in_ready), 64'd1);
    chk("stray.no_out", 64'(bus.out_valid), 64'd0);
    step();
    chk("stray.ack_drop", 64'(bus.resp_ack), 64'd0);

`ifdef MEM_STAGE_TIMEOUT_EN
    run_op("tmo", 1, 0, 64'h6000, 64'h0, 2'd3, 0, 1, 0, -1, 64'h0, 1, 64'h0, 1);
    bus.resp_cyc = 1'b1; bus.resp_data = 64'h1234;
    step();
    bus.resp_cyc = 1'b0;
    chk("late.ack", 64'(bus.resp_ack), 64'd1);
    chk("late.no_out", 64'(bus.out_valid), 64'd0);
    step();
`endif

    bus.in_valid = 1'b1; bus.in_is_load = 1'b1; bus.in_is_store = 1'b0;
    bus.in_addr = 64'h4000; bus.in_size = 2'd3; bus.in_tag = 13'h1AB;
    step();
    bus.in_valid = 1'b0;
    bus.req_ack = 1'b1;
    step();
    bus.req_ack = 1'b0;
    chk("mid.in_resp", 64'(bus.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid.req_cyc", 64'(bus.req_cyc), 64'd0);
    chk("mid.req_addr", bus.req_addr, 64'h0);
    chk("mid.req_tag", 64'(bus.req_tag), 64'd0);
    chk("mid.req_be", 64'(bus.req_be), 64'd0);
    chk("mid.out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid.out_data", bus.out_load_data, 64'h0);
    chk("mid.resp_ack", 64'(bus.resp_ack), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench watchdog expired");
  end
endmodule
